// File: rtl/att_autorange_pkg.sv
// Shared types and helpers for the channel-A attenuation auto-ranging controller.
// State encoding, attenuation code limits and manual code clamping.
package att_autorange_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_MEASURE,
        ST_DECIDE
    } state_t;

    localparam int ATT_CODE_W   = 4;
    localparam int ATT_MAX_CODE = 9;

    function automatic logic [ATT_CODE_W-1:0] clamp_code(
        input logic [ATT_CODE_W-1:0] code
    );
        if (code > ATT_CODE_W'(ATT_MAX_CODE))
            return ATT_CODE_W'(ATT_MAX_CODE);
        return code;
    endfunction

endpackage

// File: rtl/att_peak_detect.sv
// Window peak detector: sample magnitude with saturation, clip flag,
// running window maximum and sample count.
module att_peak_detect #(
    parameter int ADC_W      = 12,
    parameter int WINDOW_LEN = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             clear,
    input  logic             abort_en,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    output logic [ADC_W-2:0] peak,
    output logic             window_done
);

    localparam int CNT_W = $clog2(WINDOW_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_LEN - 1);
    localparam logic [ADC_W-1:0] POS_FS = {1'b0, {(ADC_W-1){1'b1}}};
    localparam logic [ADC_W-1:0] NEG_FS = {1'b1, {(ADC_W-1){1'b0}}};
    localparam logic [ADC_W-2:0] MAG_FS = '1;

    logic [CNT_W-1:0] count;
    logic [ADC_W-2:0] mag;
    logic             clip;
    logic             fire;

    always_comb begin
        mag = adc_data[ADC_W-2:0];
        if (adc_data == NEG_FS)
            mag = MAG_FS;
        else if (adc_data[ADC_W-1])
            mag = (ADC_W-1)'(-adc_data);
    end

    assign clip = (adc_data == POS_FS) || (adc_data == NEG_FS);
    assign fire = !clear && adc_valid;

    // A clip already has full-scale magnitude, so aborting just ends the window
    assign window_done = fire && ((count == CNT_LAST) || (abort_en && clip));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            peak  <= '0;
            count <= '0;
        end else if (clear) begin
            peak  <= '0;
            count <= '0;
        end else if (fire) begin
            count <= count + 1'b1;
            if (mag > peak)
                peak <= mag;
        end
    end

endmodule

// File: rtl/att_autorange_ctrl.sv
// Channel-A auto-ranging controller: steps the HC595 attenuation code from
// windowed peak measurements, with manual override, restart and lock status.
module att_autorange_ctrl
    import att_autorange_pkg::*;
#(
    parameter int ADC_W         = 12,
    parameter int WINDOW_LEN    = 1024,
    parameter int SETTLE_CYCLES = 4096,
    parameter int HI_THR        = 1800,
    parameter int LO_THR        = 700,
    parameter int LOCK_COUNT    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADC_W-1:0]      i_adc_data,
    input  logic                  i_adc_valid,
    input  logic                  i_auto_en,
    input  logic [ATT_CODE_W-1:0] i_manual_code,
    input  logic                  i_restart,
    output logic [ATT_CODE_W-1:0] o_ATT_A,
    output logic [ADC_W-2:0]      o_peak,
    output logic                  o_peak_valid,
    output logic                  o_locked,
    output logic                  o_range_err
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_FULL   = LW'(LOCK_COUNT);
    localparam logic [ADC_W-2:0] HI = (ADC_W-1)'(HI_THR);
    localparam logic [ADC_W-2:0] LO = (ADC_W-1)'(LO_THR);
    localparam logic [ATT_CODE_W-1:0] MAX_CODE = ATT_CODE_W'(ATT_MAX_CODE);

    state_t                state_q, state_d;
    logic [ATT_CODE_W-1:0] code_q, code_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [LW-1:0]         lock_q, lock_d;
    logic                  err_q, err_d;
    logic                  auto_q;
    logic [ADC_W-2:0]      det_peak;
    logic                  win_done;
    logic [ATT_CODE_W-1:0] man_code;

    assign man_code = clamp_code(i_manual_code);

    att_peak_detect #(
        .ADC_W      (ADC_W),
        .WINDOW_LEN (WINDOW_LEN)
    ) u_peak (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .clear       (state_q != ST_MEASURE),
        .abort_en    (i_auto_en),
        .adc_data    (i_adc_data),
        .adc_valid   (i_adc_valid),
        .peak        (det_peak),
        .window_done (win_done)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        settle_d = settle_q;
        lock_d   = lock_q;
        err_d    = err_q;

        unique case (state_q)
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_MEASURE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (win_done)
                    state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                state_d = ST_MEASURE;
                if (i_auto_en) begin
                    if (det_peak >= HI) begin
                        lock_d = '0;
                        if (code_q < MAX_CODE) begin
                            code_d  = code_q + 1'b1;
                            state_d = ST_SETTLE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (det_peak < LO && code_q != '0) begin
                        code_d  = code_q - 1'b1;
                        lock_d  = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        err_d = 1'b0;
                        if (lock_q != LOCK_FULL)
                            lock_d = lock_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_SETTLE;
        endcase

        // Restart beats a mode change, which beats a manual code change
        if (i_restart) begin
            code_d   = MAX_CODE;
            lock_d   = '0;
            err_d    = 1'b0;
            state_d  = ST_SETTLE;
            settle_d = '0;
        end else if (i_auto_en != auto_q) begin
            if (!i_auto_en)
                code_d = man_code;
            lock_d   = '0;
            state_d  = ST_SETTLE;
            settle_d = '0;
        end else if (!i_auto_en && man_code != code_q) begin
            code_d   = man_code;
            lock_d   = '0;
            state_d  = ST_SETTLE;
            settle_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_SETTLE;
            code_q       <= MAX_CODE;
            settle_q     <= '0;
            lock_q       <= '0;
            err_q        <= 1'b0;
            auto_q       <= 1'b1;
            o_peak       <= '0;
            o_peak_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            settle_q     <= settle_d;
            lock_q       <= lock_d;
            err_q        <= err_d;
            auto_q       <= i_auto_en;
            o_peak_valid <= (state_q == ST_DECIDE);
            if (state_q == ST_DECIDE)
                o_peak <= det_peak;
        end
    end

    assign o_ATT_A     = code_q;
    assign o_locked    = (lock_q == LOCK_FULL);
    assign o_range_err = err_q;

endmodule

// File: tb/tb_att_autorange_ctrl.sv
// Bench for att_autorange_ctrl: directed ranging scenarios, a manual-mode
// peak table and a randomized run against a window-level reference model.
module tb_att_autorange_ctrl;

    localparam int ADC_W = 12;
    localparam int WL    = 16;
    localparam int SC    = 32;
    localparam int HI    = 1800;
    localparam int LO    = 700;
    localparam int LC    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADC_W-1:0]  adc = '0;
    logic              vld = 1'b0;
    logic              auto_en = 1'b1;
    logic [3:0]        man = '0;
    logic              restart = 1'b0;
    logic [3:0]        att;
    logic [ADC_W-2:0]  peak;
    logic              pv;
    logic              locked;
    logic              rerr;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    bit rnd_mode = 0;
    bit exact = 0;
    int amp = 0;

    typedef struct {
        bit v;
        int mag;
    } hist_t;
    hist_t hist[$];

    typedef struct {
        int val;
        int exp_peak;
    } vec_t;
    vec_t tbl[10];

    att_autorange_ctrl #(
        .ADC_W         (ADC_W),
        .WINDOW_LEN    (WL),
        .SETTLE_CYCLES (SC),
        .HI_THR        (HI),
        .LO_THR        (LO),
        .LOCK_COUNT    (LC)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_adc_data    (adc),
        .i_adc_valid   (vld),
        .i_auto_en     (auto_en),
        .i_manual_code (man),
        .i_restart     (restart),
        .o_ATT_A       (att),
        .o_peak        (peak),
        .o_peak_valid  (pv),
        .o_locked      (locked),
        .o_range_err   (rerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
    endtask

    task automatic fail_to(input string nm);
        total++;
        $display("FAIL %s: no o_peak_valid within bound (cycle %0d)", nm, cyc);
    endtask

    task automatic tick();
        int s;
        @(posedge clk);
        #1;
        cyc++;
        if (rnd_mode) begin
            vld = ($urandom_range(0, 3) != 0);
            if (exact)
                s = ($urandom_range(0, 1) == 1) ? amp : -amp;
            else
                s = int'($urandom_range(0, 2 * amp)) - amp;
            adc = ADC_W'(s);
            hist.push_back('{vld, (s < 0) ? -s : s});
            if (hist.size() > 400)
                void'(hist.pop_front());
        end
    endtask

    task automatic wait_pv(input string nm, input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            tick();
            if (pv)
                ok = 1;
        end
        if (!ok)
            fail_to(nm);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_att"}, att, 9);
        chk({nm, "_peak"}, peak, 0);
        chk({nm, "_pv"}, pv, 0);
        chk({nm, "_locked"}, locked, 0);
        chk({nm, "_rerr"}, rerr, 0);
    endtask

    initial begin
        bit ok;
        bit seen;
        int last;
        int n;
        int p_att;
        int p_lock;
        int m_code;
        int m_lock;
        int m_err;
        int npv;

        tbl[0] = '{100, 100};
        tbl[1] = '{-100, 100};
        tbl[2] = '{0, 0};
        tbl[3] = '{2047, 2047};
        tbl[4] = '{-2048, 2047};
        tbl[5] = '{-2047, 2047};
        tbl[6] = '{1799, 1799};
        tbl[7] = '{1800, 1800};
        tbl[8] = '{699, 699};
        tbl[9] = '{-700, 700};

        tick();
        chk_reset("reset");
        rst_n = 1'b1;

        // Fixed amplitude 100 walks the code from 9 down to 0
        adc = 12'd100;
        vld = 1'b1;
        last = cyc;
        for (int c = 8; c >= 0; c--) begin
            wait_pv("stepdown", 200, ok);
            chk("step_code", att, c);
            chk("settle_gap", int'(cyc - last >= 33), 1);
            last = cyc;
        end
        wait_pv("lock1", 100, ok);
        chk("lock1_att", att, 0);
        chk("lock1_locked", locked, 0);
        wait_pv("lock2", 100, ok);
        chk("lock2_locked", locked, 1);

        // Walk up to code 3, lock there, then overrange
        adc = 12'd1900;
        for (int c = 1; c <= 3; c++) begin
            wait_pv("stepup", 200, ok);
            chk("stepup_code", att, c);
        end
        adc = 12'd1000;
        wait_pv("lock3a", 100, ok);
        wait_pv("lock3b", 100, ok);
        chk("lock3_att", att, 3);
        chk("lock3_locked", locked, 1);
        adc = 12'd1900;
        seen = 0;
        p_att = 0;
        p_lock = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            p_att = att;
            p_lock = locked;
            tick();
            if (pv)
                seen = 1;
        end
        if (seen) begin
            chk("over_prev_att", p_att, 3);
            chk("over_prev_locked", p_lock, 1);
            chk("over_att", att, 4);
            chk("over_locked", locked, 0);
        end else begin
            fail_to("over");
        end

        // Clip at code 9 aborts the window
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        adc = 12'd1000;
        vld = 1'b1;
        repeat (40) tick();
        adc = 12'd2047;
        tick();
        chk("clip_decide_pv", pv, 0);
        adc = 12'd1000;
        tick();
        chk("clip_pv", pv, 1);
        chk("clip_peak", peak, 2047);
        chk("clip_rerr", rerr, 1);
        chk("clip_att", att, 9);

        // In-band amplitude: peak reported once per window, no code change
        for (int k = 0; k < 3; k++) begin
            wait_pv("inband", 100, ok);
            chk("inband_peak", peak, 1000);
            chk("inband_rerr", rerr, 0);
            chk("inband_att", att, 9);
            chk("inband_locked", locked, int'(k >= 1));
            tick();
            chk("pv_one_cycle", pv, 0);
        end

        // Manual mode with clamping
        auto_en = 1'b0;
        man = 4'd12;
        tick();
        chk("man12_att", att, 9);
        chk("man12_locked", locked, 0);
        man = 4'd5;
        tick();
        chk("man5_att", att, 5);
        n = 0;
        repeat (30) begin
            tick();
            if (pv)
                n++;
        end
        chk("man5_settle_pv", n, 0);
        for (int t = 0; t < 10; t++) begin
            adc = ADC_W'(tbl[t].val);
            wait_pv("tbl_a", 200, ok);
            wait_pv("tbl_b", 200, ok);
            chk("tbl_peak", peak, tbl[t].exp_peak);
            chk("tbl_att", att, 5);
            chk("tbl_locked", locked, 0);
        end

        // Restart during an underrange DECIDE cycle
        auto_en = 1'b1;
        vld = 1'b0;
        repeat (40) tick();
        adc = 12'd100;
        vld = 1'b1;
        repeat (16) tick();
        chk("rs_decide_pv", pv, 0);
        chk("rs_decide_att", att, 5);
        vld = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_att", att, 9);
        chk("rs_pv", pv, 1);
        chk("rs_peak", peak, 100);
        vld = 1'b1;
        n = 0;
        repeat (40) begin
            tick();
            if (pv)
                n++;
        end
        chk("rs_settle_pv", n, 0);
        chk("rs_settle_att", att, 9);

        // Asynchronous reset in the middle of a window
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        tick();
        tick();

        // Randomized windows against a window-level model
        hist.delete();
        amp = 500;
        exact = 0;
        rnd_mode = 1;
        m_code = 9;
        m_lock = 0;
        m_err = 0;
        npv = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (pv) begin
                int pk;
                int cnt;
                pk = 0;
                cnt = 0;
                for (int j = hist.size() - 3; j >= 0 && cnt < WL; j--) begin
                    if (hist[j].v) begin
                        cnt++;
                        if (hist[j].mag > pk)
                            pk = hist[j].mag;
                    end
                end
                if (pk >= HI) begin
                    m_lock = 0;
                    if (m_code < 9)
                        m_code++;
                    else
                        m_err = 1;
                end else if (pk < LO && m_code > 0) begin
                    m_code--;
                    m_lock = 0;
                end else begin
                    m_err = 0;
                    m_lock = (m_lock < LC) ? m_lock + 1 : LC;
                end
                chk("rnd_peak", peak, pk);
                chk("rnd_att", att, m_code);
                chk("rnd_rerr", rerr, m_err);
                chk("rnd_locked", locked, int'(m_lock == LC));
                npv++;
                if ($urandom_range(0, 3) == 0) begin
                    exact = 1;
                    case ($urandom_range(0, 3))
                        0: amp = 699;
                        1: amp = 700;
                        2: amp = 1799;
                        default: amp = 1800;
                    endcase
                end else begin
                    exact = 0;
                    amp = $urandom_range(0, 2046);
                end
            end else begin
                chk("rnd_att_hold", att, m_code);
            end
        end
        chk("rnd_windows", int'(npv >= 20), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
